morse_tx_arbiter: RTL and testbench
===================================

// Module: morse_tx_arbiter
// PURPOSE
//  Shares one Morse line driver between two character requesters and sequences the keying.
//  Each requester offers a pre-encoded character (length + dot/dash pattern) on a valid/ready handshake.
//  A round-robin arbiter grants one request at a time; a keyer FSM then drives o_data_morse.
//  Timing unit U = UNIT_CYCLES clocks: dot = 1U high, dash = 3U high, intra-symbol space = 1U low.
//  Inter-letter gap = 3U low; inter-word gap = 7U low.
//  Sits in front of the receiver side of the link, replacing a fixed-message sender.
// PARAMETERS
//  UNIT_CYCLES  4  clocks per Morse time unit; legal range 1..255.
//  CNT_W        clog2(7*UNIT_CYCLES)  width of the unit/cycle counter; derived, not overridden.
// PORTS
//  i_clk         in   1  clock; all logic rises on posedge.
//  i_rst         in   1  synchronous, active-high reset.
//  i_valid0      in   1  requester 0 offers a character.
//  i_len0        in   3  requester 0 symbol count; legal 1..6.
//  i_pat0        in   6  requester 0 pattern; bit0 is sent first; 1 = dash, 0 = dot.
//  i_eow0        in   1  requester 0 character ends a word: use 7U gap instead of 3U.
//  o_ready0      out  1  requester 0 handshake; transfer on i_valid0 & o_ready0.
//  i_valid1, i_len1, i_pat1, i_eow1, o_ready1  same as requester 0, for requester 1.
//  o_data_morse  out  1  keyed Morse line; 1 = mark.
//  o_busy        out  1  high whenever the FSM is not IDLE.
//  o_grant       out  1  index of the requester whose character is in flight; holds its value in IDLE.
//  o_done        out  1  one-cycle pulse when a character's trailing gap completes.
//  o_err         out  1  one-cycle pulse when an illegal length (0 or 7) is accepted.
// BEHAVIOUR
//  Reset state: IDLE; o_data_morse = 0; o_busy = 0; o_done = 0; o_err = 0; o_grant = 0; last_grant = 1.
//  While i_rst is high, outputs hold these values.
//  Reset mid-character: the character is abandoned and the line goes low on the next edge.
//  Arbitration (IDLE only, combinational):
//  - One valid: that requester wins.
//  - Both valid: the winner is !last_grant.
//  - o_readyN = (state == IDLE) & winner == N. Ready is never high outside IDLE, and never high for both.
//  On transfer (registered):
//  - Latch len, pat, eow; last_grant <= winner; o_grant <= winner.
//  - Legal length: go to MARK with the symbol index = 0.
//  - Illegal length (0 or 7): pulse o_err next cycle, stay IDLE, line stays low; o_done does not pulse.
//  FSM states:
//  - IDLE: line low; arbitrate as above.
//  - MARK: line high for U cycles (pat[idx] = 0) or 3U cycles (pat[idx] = 1).
//    Then go to SPACE if idx + 1 < len, else to GAP.
//  - SPACE: line low for U cycles; idx <= idx + 1; back to MARK.
//  - GAP: line low for 3U-1 cycles (eow = 0) or 7U-1 cycles (eow = 1).
//    o_done pulses on the cycle the FSM re-enters IDLE.
//  The IDLE accept cycle supplies the final gap cycle, so back-to-back letters see exactly 3U/7U low.
//  Latency: first mark cycle is the cycle after the transfer edge.
//  The counter reloads on every state entry and counts down to 0; there is no wrap.
//  Inputs are ignored outside IDLE; a requester may change its inputs freely while not ready.
//  pat bits at index >= len are don't-care.
// TESTING  (UNIT_CYCLES = 4; cycle 0 = transfer edge)
//  1. req0 'E' (len=1, pat=000000, eow=0):
//     o_ready0 high in cycle 0; line high cycles 1-4, low cycles 5-15; o_done at cycle 16; o_busy low at 16.
//  2. req1 'A' (len=2, pat=000010):
//     line high 4, low 4, high 12, low 11; o_grant = 1; o_done once.
//  3. Both valid continuously with 'E':
//     grants alternate 0,1,0,1; each letter starts exactly 12 low cycles after the previous mark ends.
//  4. req0 'T' (len=1, pat=1, eow=1): line high 12 cycles, then low 27 cycles; o_done pulses.
//  5. req0 len=0:
//     o_ready0 pulses, o_err pulses in the next cycle, line never rises, o_busy stays 0, no o_done.
//  6. i_rst asserted mid-dash:
//     line low and o_busy = 0 on the next edge.
//     After release with both requesters valid, req0 is granted first.

Source files
------------

// File: rtl/morse_tx_arbiter.sv
// morse_tx_arbiter: round-robin share of one Morse keyer between two pre-encoded character requesters.
// Latency: first mark cycle follows the transfer edge; o_done pulses the cycle IDLE is re-entered.
// Backpressure: ready is offered only in IDLE, only to the arbitration winner; inputs ignored while keying.
module morse_tx_arbiter #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid0,
  input  logic [2:0] i_len0,
  input  logic [5:0] i_pat0,
  input  logic       i_eow0,
  output logic       o_ready0,
  input  logic       i_valid1,
  input  logic [2:0] i_len1,
  input  logic [5:0] i_pat1,
  input  logic       i_eow1,
  output logic       o_ready1,
  output logic       o_data_morse,
  output logic       o_busy,
  output logic       o_grant,
  output logic       o_done,
  output logic       o_err
);

  localparam int CNT_W = $clog2(7 * UNIT_CYCLES);

  // Reload values: the counter runs from the load value down to 0, so each is duration - 1.
  // Gaps are one cycle short because the IDLE accept cycle supplies the last low cycle.
  localparam logic [CNT_W-1:0] DOT_LD   = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LD  = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPACE_LD = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LGAP_LD  = CNT_W'(3 * UNIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] WGAP_LD  = CNT_W'(7 * UNIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       idx;
  logic [2:0]       idx_nxt;
  logic [2:0]       idx_inc;
  logic [2:0]       len_q;
  logic [5:0]       pat_q;
  logic             eow_q;
  logic             last_grant;
  logic             grant_q;
  logic             done_q;
  logic             err_q;

  logic             win;
  logic             xfer;
  logic [2:0]       win_len;
  logic [5:0]       win_pat;
  logic             win_eow;
  logic             win_legal;

  // Round-robin arbitration: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    win = i_valid1;
    if (i_valid0 && i_valid1) begin
      win = ~last_grant;
    end
    win_len   = win ? i_len1 : i_len0;
    win_pat   = win ? i_pat1 : i_pat0;
    win_eow   = win ? i_eow1 : i_eow0;
    win_legal = (win_len != 3'd0) && (win_len != 3'd7);
    xfer      = (state == ST_IDLE) && (i_valid0 || i_valid1) && !i_rst;
  end

  // State register plus latched character, grant history and one-cycle status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      len_q      <= '0;
      pat_q      <= '0;
      eow_q      <= 1'b0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      done_q <= (state == ST_GAP) && (cnt == '0);
      err_q  <= xfer && !win_legal;
      if (xfer) begin
        len_q      <= win_len;
        pat_q      <= win_pat;
        eow_q      <= win_eow;
        last_grant <= win;
        grant_q    <= win;
      end
    end
  end

  // Next-state logic: every state entry reloads the counter; a state ends when it reaches 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    idx_inc   = idx + 3'd1;
    case (state)
      ST_IDLE: begin
        if (xfer && win_legal) begin
          state_nxt = ST_MARK;
          idx_nxt   = '0;
          cnt_nxt   = win_pat[0] ? DASH_LD : DOT_LD;
        end
      end
      ST_MARK: begin
        if (cnt == '0) begin
          if (idx_inc < len_q) begin
            state_nxt = ST_SPACE;
            cnt_nxt   = SPACE_LD;
          end else begin
            state_nxt = ST_GAP;
            cnt_nxt   = eow_q ? WGAP_LD : LGAP_LD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_SPACE: begin
        if (cnt == '0) begin
          state_nxt = ST_MARK;
          idx_nxt   = idx_inc;
          cnt_nxt   = pat_q[idx_inc] ? DASH_LD : DOT_LD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: line keyed straight from the state, handshakes from the arbiter.
  always_comb begin
    o_data_morse = (state == ST_MARK);
    o_busy       = (state != ST_IDLE);
    o_ready0     = xfer && !win;
    o_ready1     = xfer && win;
    o_grant      = grant_q;
    o_done       = done_q;
    o_err        = err_q;
  end

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// tb_morse_tx_arbiter: directed scenarios plus randomized traffic against a waveform-queue reference.
// Latency: reference predicts every output each cycle, sampled on the falling edge.
// Backpressure: requesters hold valid until their ready is seen, or change inputs freely in random phase.
module tb_morse_tx_arbiter;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid0, valid1;
  logic [2:0] len0, len1;
  logic [5:0] pat0, pat1;
  logic       eow0, eow1;
  logic       ready0, ready1;
  logic       data_morse, busy, grant, done, err;

  always #5 clk = ~clk;

  morse_tx_arbiter #(.UNIT_CYCLES(U)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid0     (valid0),
    .i_len0       (len0),
    .i_pat0       (pat0),
    .i_eow0       (eow0),
    .o_ready0     (ready0),
    .i_valid1     (valid1),
    .i_len1       (len1),
    .i_pat1       (pat1),
    .i_eow1       (eow1),
    .o_ready1     (ready1),
    .o_data_morse (data_morse),
    .o_busy       (busy),
    .o_grant      (grant),
    .o_done       (done),
    .o_err        (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each accepted legal character becomes a queue of future line levels.
  bit m_q[$];
  bit m_last  = 1'b1;
  bit m_grant = 1'b0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  function automatic void build_wave(input logic [2:0] len, input logic [5:0] pat, input logic eow);
    for (int s = 0; s < int'(len); s++) begin
      for (int c = 0; c < (pat[s] ? 3 * U : U); c++) m_q.push_back(1'b1);
      if (s < int'(len) - 1)
        for (int c = 0; c < U; c++) m_q.push_back(1'b0);
    end
    for (int c = 0; c < (eow ? 7 * U : 3 * U) - 1; c++) m_q.push_back(1'b0);
  endfunction

  // Per-cycle comparison of every output against the reference, then advance the reference.
  always @(negedge clk) begin
    bit idle, w, xf, nd, ne;
    logic [2:0] ln;
    logic [5:0] pt;
    logic eo;
    idle = (m_q.size() == 0);
    w    = (valid0 && valid1) ? !m_last : valid1;
    xf   = idle && !rst && (valid0 || valid1);
    chk("line",   int'(data_morse), idle ? 0 : int'(m_q[0]));
    chk("busy",   int'(busy),       idle ? 0 : 1);
    chk("ready0", int'(ready0),     int'(xf && !w));
    chk("ready1", int'(ready1),     int'(xf && w));
    chk("grant",  int'(grant),      int'(m_grant));
    chk("done",   int'(done),       int'(m_done));
    chk("err",    int'(err),        int'(m_err));
    nd = 1'b0;
    ne = 1'b0;
    if (rst) begin
      m_q.delete();
      m_last  = 1'b1;
      m_grant = 1'b0;
    end else if (!idle) begin
      void'(m_q.pop_front());
      nd = (m_q.size() == 0);
    end else if (xf) begin
      ln = w ? len1 : len0;
      pt = w ? pat1 : pat0;
      eo = w ? eow1 : eow0;
      m_last  = w;
      m_grant = w;
      if (ln >= 3'd1 && ln <= 3'd6) build_wave(ln, pt, eo);
      else ne = 1'b1;
    end
    m_done = nd;
    m_err  = ne;
  end

  task automatic set_req(input int r, input logic v, input logic [2:0] l, input logic [5:0] p, input logic e);
    if (r == 0) begin valid0 = v; len0 = l; pat0 = p; eow0 = e; end
    else        begin valid1 = v; len1 = l; pat1 = p; eow1 = e; end
  endtask

  // Offer one character and drop valid right after the transfer edge.
  task automatic send(input int r, input logic [2:0] l, input logic [5:0] p, input logic e);
    bit got = 1'b0;
    set_req(r, 1'b1, l, p, e);
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if ((r == 0 && ready0) || (r == 1 && ready1)) got = 1'b1;
    end
    chk("send_handshake", int'(got), 1);
    @(posedge clk);
    #1;
    set_req(r, 1'b0, l, p, e);
  endtask

  // Count mark cycles and the cycle of o_done, numbering the cycle after transfer as 1.
  task automatic measure(output int hi, output int done_at);
    hi = 0;
    done_at = -1;
    for (int c = 1; c <= 80 && done_at < 0; c++) begin
      @(negedge clk);
      if (data_morse) hi++;
      if (done) done_at = c;
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 600 && !ok; k++) begin
      @(posedge clk);
      #2;
      if (m_q.size() == 0 && !m_done && !m_err) ok = 1'b1;
    end
    chk("drain", int'(ok), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hi, dat;
    bit got;
    rst = 1'b1;
    set_req(0, 1'b0, 3'd0, 6'd0, 1'b0);
    set_req(1, 1'b0, 3'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("rst_line",  int'(data_morse), 0);
    chk("rst_busy",  int'(busy),       0);
    chk("rst_grant", int'(grant),      0);
    chk("rst_done",  int'(done),       0);
    chk("rst_err",   int'(err),        0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 'E' from requester 0
    send(0, 3'd1, 6'b000000, 1'b0);
    measure(hi, dat);
    chk("E_marks", hi, 4);
    chk("E_done_cycle", dat, 16);
    drain();

    // 'A' from requester 1
    send(1, 3'd2, 6'b000010, 1'b0);
    chk("A_grant", int'(grant), 1);
    measure(hi, dat);
    chk("A_marks", hi, 16);
    chk("A_done_cycle", dat, 32);
    drain();

    // Both requesters hold 'E': grants must alternate starting with requester 0
    set_req(0, 1'b1, 3'd1, 6'd0, 1'b0);
    set_req(1, 1'b1, 3'd1, 6'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        if (ready0 || ready1) got = 1'b1;
      end
      chk("alt_handshake", int'(got), 1);
      chk("alt_grant", int'(ready1), k % 2);
      @(posedge clk);
    end
    #1;
    set_req(0, 1'b0, 3'd1, 6'd0, 1'b0);
    set_req(1, 1'b0, 3'd1, 6'd0, 1'b0);
    drain();

    // 'T' ending a word
    send(0, 3'd1, 6'b000001, 1'b1);
    measure(hi, dat);
    chk("T_marks", hi, 12);
    chk("T_done_cycle", dat, 40);
    drain();

    // Illegal length 0 and 7
    send(0, 3'd0, 6'd0, 1'b0);
    @(negedge clk);
    chk("len0_err", int'(err), 1);
    chk("len0_busy", int'(busy), 0);
    drain();
    send(1, 3'd7, 6'b111111, 1'b0);
    @(negedge clk);
    chk("len7_err", int'(err), 1);
    drain();

    // Reset in the middle of a dash
    send(0, 3'd1, 6'b000001, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_line", int'(data_morse), 0);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    set_req(0, 1'b1, 3'd1, 6'd0, 1'b0);
    set_req(1, 1'b1, 3'd1, 6'd0, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (ready0 || ready1) got = 1'b1;
    end
    chk("midrst_handshake", int'(got), 1);
    chk("midrst_first_req0", int'(ready0), 1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 3'd1, 6'd0, 1'b0);
    set_req(1, 1'b0, 3'd1, 6'd0, 1'b0);
    drain();

    // Randomized traffic with occasional illegal lengths and resets
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 799) == 0);
      for (int r = 0; r < 2; r++) begin
        if ($urandom_range(0, 2) == 0) begin
          logic [2:0] l;
          if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
          else l = 3'($urandom_range(1, 6));
          set_req(r, ($urandom_range(0, 3) != 0), l, 6'($urandom), 1'($urandom));
        end
      end
    end
    rst = 1'b0;
    set_req(0, 1'b0, 3'd0, 6'd0, 1'b0);
    set_req(1, 1'b0, 3'd0, 6'd0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
